// File: rtl/datapath_param_if.sv
// Control-unit side of the datapath: bus source and destination selects,
// register load strobes and the ALU start/busy/done handshake.
interface datapath_param_if #(
    parameter int NREGS = 16
) ();
    localparam int SELW = $clog2(NREGS);

    logic [3:0]      src_sel;
    logic [SELW-1:0] rsrc;
    logic [SELW-1:0] rdst;
    logic            rdst_we;
    logic            hi_in;
    logic            lo_in;
    logic            pc_in;
    logic            mdr_in;
    logic            mar_in;
    logic            ir_in;
    logic            y_in;
    logic            cse_in;
    logic            mdr_rd;
    logic [3:0]      alu_op;
    logic            alu_go;
    logic            alu_busy;
    logic            alu_done;

    modport master (
        output src_sel, rsrc, rdst, rdst_we,
        output hi_in, lo_in, pc_in, mdr_in, mar_in, ir_in, y_in, cse_in, mdr_rd,
        output alu_op, alu_go,
        input  alu_busy, alu_done
    );

    modport slave (
        input  src_sel, rsrc, rdst, rdst_we,
        input  hi_in, lo_in, pc_in, mdr_in, mar_in, ir_in, y_in, cse_in, mdr_rd,
        input  alu_op, alu_go,
        output alu_busy, alu_done
    );
endinterface

// File: rtl/datapath_param.sv
// Single-bus CPU datapath: general register file, special registers, a
// single-cycle ALU and an iterative shift-add multiplier / restoring divider.
module datapath_param #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic               clock,
    input  logic               clear,
    datapath_param_if.slave    ctrl,
    input  logic [WIDTH-1:0]   mdata_in,
    input  logic               inport_strobe,
    input  logic [WIDTH-1:0]   inport_data,
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   mar_out,
    output logic [WIDTH-1:0]   mdr_out,
    output logic [WIDTH-1:0]   ir_out,
    output logic [WIDTH-1:0]   pc_out
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    logic [WIDTH-1:0] gpr [NREGS];
    logic [WIDTH-1:0] hi, lo, zhigh, zlow, pc, mdr, mar, ir, y, inport, cse;
    logic [WIDTH-1:0] bus;

    state_t           state;
    logic [CW-1:0]    iter;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_result;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    always_comb begin
        bus = '0;
        case (ctrl.src_sel)
            4'd1:    bus = gpr[ctrl.rsrc];
            4'd2:    bus = hi;
            4'd3:    bus = lo;
            4'd4:    bus = zhigh;
            4'd5:    bus = zlow;
            4'd6:    bus = pc;
            4'd7:    bus = mdr;
            4'd8:    bus = inport;
            4'd9:    bus = cse;
            default: bus = '0;
        endcase
    end

    assign bus_out       = bus;
    assign mar_out       = mar;
    assign mdr_out       = mdr;
    assign ir_out        = ir;
    assign pc_out        = pc;
    assign ctrl.alu_busy = busy;
    assign ctrl.alu_done = done;

    // Single-cycle results use the live Y and bus, since they commit on the go edge.
    assign shamt = bus[SHW-1:0];

    always_comb begin
        simple_result = bus;
        case (ctrl.alu_op)
            OP_ADD:  simple_result = y + bus;
            OP_SUB:  simple_result = y - bus;
            OP_AND:  simple_result = y & bus;
            OP_OR:   simple_result = y | bus;
            OP_SHR:  simple_result = y >> shamt;
            OP_SHRA: simple_result = WIDTH'($signed(y) >>> shamt);
            OP_SHL:  simple_result = y << shamt;
            OP_ROR:  simple_result = WIDTH'({y, y} >> shamt);
            OP_ROL:  simple_result = WIDTH'(({y, y} << shamt) >> WIDTH);
            OP_NEG:  simple_result = '0 - bus;
            OP_NOT:  simple_result = ~bus;
            OP_INC:  simple_result = bus + WIDTH'(1);
            default: simple_result = bus;
        endcase
    end

    // Multiplier keeps the partial product in work_hi and the unconsumed multiplier in work_lo.
    assign mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : {(WIDTH + 1){1'b0}});
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

    // Divider: work_hi is the partial remainder, work_lo shifts dividend bits out and quotient bits in.
    assign div_shift    = {work_hi, work_lo[WIDTH-1]};
    assign div_fits     = div_shift >= {1'b0, op_b};
    assign div_rem_next = div_fits ? (div_shift[WIDTH-1:0] - op_b) : div_shift[WIDTH-1:0];
    assign div_quo_next = {work_lo[WIDTH-2:0], div_fits};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
            hi     <= '0;
            lo     <= '0;
            pc     <= '0;
            mdr    <= '0;
            mar    <= '0;
            ir     <= '0;
            y      <= '0;
            inport <= '0;
            cse    <= '0;
        end else begin
            if (ctrl.rdst_we) gpr[ctrl.rdst] <= bus;
            if (ctrl.hi_in)   hi  <= bus;
            if (ctrl.lo_in)   lo  <= bus;
            if (ctrl.pc_in)   pc  <= bus;
            if (ctrl.mar_in)  mar <= bus;
            if (ctrl.ir_in)   ir  <= bus;
            if (ctrl.y_in)    y   <= bus;
            if (ctrl.cse_in)  cse <= bus;
            if (ctrl.mdr_in)  mdr <= ctrl.mdr_rd ? mdata_in : bus;
            if (inport_strobe) inport <= inport_data;
        end
    end

    // A go seen while busy is dropped; Z only changes when an operation completes.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            iter    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            zhigh   <= '0;
            zlow    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.alu_go) begin
                        case (ctrl.alu_op)
                            OP_MUL: begin
                                state   <= MUL;
                                busy    <= 1'b1;
                                iter    <= '0;
                                op_a    <= y;
                                work_hi <= '0;
                                work_lo <= bus;
                            end
                            OP_DIV: begin
                                state   <= DIV;
                                busy    <= 1'b1;
                                iter    <= '0;
                                op_a    <= y;
                                op_b    <= bus;
                                work_hi <= '0;
                                work_lo <= y;
                            end
                            default: begin
                                zlow  <= simple_result;
                                zhigh <= '0;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    work_hi <= mul_hi_next;
                    work_lo <= mul_lo_next;
                    iter    <= iter + CW'(1);
                    if (iter == LAST_ITER) begin
                        zhigh <= mul_hi_next;
                        zlow  <= mul_lo_next;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DIV: begin
                    if (op_b == '0) begin
                        zlow  <= '1;
                        zhigh <= op_a;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        work_hi <= div_rem_next;
                        work_lo <= div_quo_next;
                        iter    <= iter + CW'(1);
                        if (iter == LAST_ITER) begin
                            zhigh <= div_rem_next;
                            zlow  <= div_quo_next;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/datapath_param.md
# datapath_param

Parametrised bus-based CPU datapath: a general-register file of depth `NREGS`, special registers (HI, LO, Zhigh/Zlow, PC, MDR, MAR, IR, Y, InPort, CSE), and a shared single bus driven by an encoded source select. It adds an ALU with a start/busy/done handshake and an iterative multi-cycle MUL/DIV unit. It sits under the control unit, which drives selects and enables one control step per clock.

## Interface
- `WIDTH`, 32, datapath and register width; ≥ 8.
- `NREGS`, 16, general registers; power of 2, ≥ 2. `SELW = clog2(NREGS)` is derived and is not overridable.
- `clock` in 1: single clock; all state updates on its rising edge.
- `clear` in 1: reset, asynchronous, active-low.
- `src_sel` in 4: bus source. 0 = none (bus = 0), 1 = GPR[`rsrc`], 2 = HI, 3 = LO, 4 = Zhigh, 5 = Zlow, 6 = PC, 7 = MDR, 8 = InPort, 9 = CSE. Codes 10–15 drive bus = 0.
- `rsrc` in SELW: GPR read index.
- `rdst` in SELW: GPR write index.
- `rdst_we` in 1: GPR write enable.
- `hi_in`, `lo_in`, `pc_in`, `mdr_in`, `mar_in`, `ir_in`, `y_in`, `cse_in` in 1 each: register load enables from the bus.
- `mdr_rd` in 1: MDR source select (1 = `mdata_in`, 0 = bus); takes effect only when `mdr_in` = 1.
- `mdata_in` in WIDTH: memory read data.
- `inport_strobe` in 1: load InPort from `inport_data`.
- `inport_data` in WIDTH: external input.
- `alu_op` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 INC, 12 MUL, 13 DIV, 14–15 PASS.
- `alu_go` in 1: start an ALU operation.
- `alu_busy` out 1: multi-cycle operation in progress.
- `alu_done` out 1: one-cycle pulse when Z has been written.
- `bus_out` out WIDTH: current bus value (combinational).
- `mar_out`, `mdr_out`, `ir_out`, `pc_out` out WIDTH: register contents.

## Operation
- Bus is a combinational mux of the current register contents selected by `src_sel`. Any number of destinations may load the bus in the same cycle.
- ALU operands: A = Y, B = bus. Both are latched at the edge where `alu_go` is sampled high. The bus and Y may change freely afterwards.
- Single-cycle ops (0–11, 14, 15): results written to Zlow at the same edge; Zhigh ← 0.
  - ADD/SUB are mod 2^WIDTH.
  - Shift and rotate amount is `B[clog2(WIDTH)-1:0]`, applied to A. SHRA sign-fills.
  - NEG = −B; NOT = ~B; INC = B + 1; PASS = B.
- MUL: unsigned shift-add, one bit per cycle, WIDTH iterations. Result: {Zhigh, Zlow} = A × B (2·WIDTH bits).
- DIV: unsigned restoring division, WIDTH iterations. Result: Zlow = A / B, Zhigh = A % B.
  - B = 0: Zlow = all ones, Zhigh = A, written after 1 iteration.
- FSM states: IDLE, MUL, DIV, with an iteration counter of width clog2(WIDTH)+1.
  - IDLE → MUL/DIV on `alu_go` with op 12/13.
  - MUL/DIV → IDLE when the counter reaches WIDTH (or when divide-by-zero is detected).
- `alu_go` while `alu_busy` = 1 is ignored; it does not queue.
- Zhigh and Zlow read on the bus during busy return their previous values.
- A register load enable and an ALU write never target the same register: Z is written only by the ALU.

## Timing
- `clear` low: every register, the FSM, and the counter go to 0 or IDLE immediately. `alu_busy` = 0, `alu_done` = 0, and all outputs are 0. This applies mid-operation too; the operation is aborted and Z is not written.
- Register loads: the value is visible on outputs and bus sources from the cycle after the enable edge.
- Single-cycle op: Z is written at edge E (the `alu_go` edge). `alu_done` = 1 during the cycle after E. `alu_busy` stays 0.
- MUL/DIV: `alu_busy` = 1 from edge E through edge E+WIDTH. Z is written at E+WIDTH. `alu_busy` falls and `alu_done` = 1 for one cycle after E+WIDTH.
- DIV by zero: Z is written at E+1, with `alu_done` in the following cycle.
- A new `alu_go` is accepted in the cycle `alu_done` is high.

## Test plan
- Reset and transfer: assert `clear` low mid-run, then release. All outputs = 0. Then load `mdata_in` = 0x1234_5678 into MDR (`mdr_rd` = 1), drive `src_sel` = 7 with `rdst` = 5 and `rdst_we` = 1, read back with `src_sel` = 1, `rsrc` = 5 → `bus_out` = 0x1234_5678.
- ADD / SHRA / ROL:
  - Y = 7, B = 9 → Zlow = 16, Zhigh = 0, `alu_done` one cycle after E.
  - Y = 0x8000_0000, B = 4, SHRA → 0xF800_0000.
  - ROL by 1 of 0x8000_0001 → 0x0000_0003.
- MUL: Y = 0xFFFF_FFFF, B = 2 → Zhigh = 1, Zlow = 0xFFFF_FFFE. `alu_busy` high for exactly 32 cycles. Drive the bus to garbage during busy; the result is unaffected.
- DIV: 100 / 7 → Zlow = 14, Zhigh = 2. Divide by zero with A = 55 → Zlow = 0xFFFF_FFFF, Zhigh = 55, `alu_done` 2 cycles after E.
- Ignored go and abort: pulse `alu_go` (ADD) at cycle 10 of a MUL → no effect and the MUL result is correct. Assert `clear` at cycle 5 of a DIV → busy = 0, Z = 0, no `alu_done`.
- Parameter sweep: WIDTH = 8, NREGS = 4. Check 0xFF × 0xFF → {Zhigh, Zlow} = 0xFE01 with latency 8. GPR index 3 writes and reads correctly.
